// File: rtl/if_id_buffer_pkg.sv
// if_id_buffer_pkg: opcode constants, immediate-format encodings and buffer entry type
package if_id_buffer_pkg;
    localparam int PC_BITS = 32;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [1:0] IMM_SEL_I    = 2'b00;
    localparam logic [1:0] IMM_SEL_S    = 2'b01;
    localparam logic [1:0] IMM_SEL_B    = 2'b10;
    localparam logic [1:0] IMM_SEL_NONE = 2'b11;
    typedef struct packed {
        logic [31:0]        instr;
        logic [PC_BITS-1:0] pc;
        logic [1:0]         imm_sel;
    } entry_t;
endpackage

// File: rtl/if_id_buffer_imm_sel_decode.sv
// imm_sel_decode: maps an instruction opcode to the immediate format the imm stage expands
module imm_sel_decode
    import if_id_buffer_pkg::*;
(
    input  logic [6:0] opcode,
    output logic [1:0] imm_sel
);
    always_comb begin
        imm_sel = (opcode == OPC_OP_IMM || opcode == OPC_LOAD || opcode == OPC_JALR) ? IMM_SEL_I :
                  (opcode == OPC_STORE)  ? IMM_SEL_S :
                  (opcode == OPC_BRANCH) ? IMM_SEL_B : IMM_SEL_NONE;
    end
endmodule

// File: rtl/if_id_buffer.sv
// if_id_buffer: two-entry elastic IF/ID skid buffer; ready depends only on registered count
module if_id_buffer
    import if_id_buffer_pkg::*;
#(
    parameter int PC_W = PC_BITS
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [PC_W-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     out_ir,
    output logic [PC_W-1:0] out_pc,
    output logic [1:0]      out_imm_sel,
    output logic            out_uses_imm
);
    if (PC_W != PC_BITS) begin : g_pc_w_check
        $error("if_id_buffer: PC_W must equal if_id_buffer_pkg::PC_BITS");
    end

    entry_t     mem [2];
    logic [1:0] count;
    logic       head, tail;
    logic [1:0] in_imm_sel;
    logic       push, pop;

    imm_sel_decode u_dec (.opcode(in_instr[6:0]), .imm_sel(in_imm_sel));

    assign in_ready     = count != 2'd2;
    assign out_valid    = count != 2'd0;
    assign push         = in_valid && in_ready && !flush;
    assign pop          = out_valid && out_ready && !flush;
    // Stale entry contents linger after a pop or flush, so gate them off when empty.
    assign out_ir       = out_valid ? mem[head].instr : 32'd0;
    assign out_pc       = out_valid ? mem[head].pc : '0;
    assign out_imm_sel  = out_valid ? mem[head].imm_sel : IMM_SEL_NONE;
    assign out_uses_imm = out_imm_sel != IMM_SEL_NONE;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= 2'd0;
            head  <= 1'b0;
            tail  <= 1'b0;
            for (int i = 0; i < 2; i++) mem[i] <= '{instr: '0, pc: '0, imm_sel: IMM_SEL_NONE};
        end else if (flush) begin
            count <= 2'd0;
            head  <= 1'b0;
            tail  <= 1'b0;
        end else begin
            if (push) begin
                mem[tail] <= '{instr: in_instr, pc: in_pc, imm_sel: in_imm_sel};
                tail      <= ~tail;
            end
            if (pop) head <= ~head;
            count <= count + 2'(push) - 2'(pop);
        end
    end
endmodule

// File: tb/tb_if_id_buffer.sv
// tb_if_id_buffer: directed vectors with hand-computed expectations for if_id_buffer
module tb_if_id_buffer;
    logic        clk = 1'b0;
    logic        rst_n, flush, in_valid, out_ready;
    logic        in_ready, out_valid, out_uses_imm;
    logic [31:0] in_instr, in_pc, out_ir, out_pc;
    logic [1:0]  out_imm_sel;
    int          n_checks = 0;
    int          n_fails = 0;

    if_id_buffer #(.PC_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_ir(out_ir), .out_pc(out_pc),
        .out_imm_sel(out_imm_sel), .out_uses_imm(out_uses_imm)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [31:0] instr, input logic [31:0] pc);
        in_valid = 1'b1;
        in_instr = instr;
        in_pc    = pc;
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; out_ready = 1'b0;
        offer(32'h00500093, 32'h0);
        #12;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_imm_sel", 32'(out_imm_sel), 32'd3);
        check("rst_uses_imm", 32'(out_uses_imm), 32'd0);
        check("rst_out_ir", out_ir, 32'd0);
        rst_n = 1'b1;
        tick();
        check("first_valid", 32'(out_valid), 32'd1);
        check("fmt_i_sel", 32'(out_imm_sel), 32'd0);
        check("fmt_i_uses", 32'(out_uses_imm), 32'd1);
        check("fmt_i_ir", out_ir, 32'h00500093);
        out_ready = 1'b1;
        offer(32'h0020A423, 32'h4);
        tick();
        check("fmt_s_sel", 32'(out_imm_sel), 32'd1);
        check("fmt_s_uses", 32'(out_uses_imm), 32'd1);
        check("fmt_s_pc", out_pc, 32'h4);
        offer(32'h00000863, 32'h8);
        tick();
        check("fmt_b_sel", 32'(out_imm_sel), 32'd2);
        check("fmt_b_uses", 32'(out_uses_imm), 32'd1);
        check("fmt_b_pc", out_pc, 32'h8);
        offer(32'h000010B7, 32'hC);
        tick();
        check("fmt_none_sel", 32'(out_imm_sel), 32'd3);
        check("fmt_none_uses", 32'(out_uses_imm), 32'd0);
        check("fmt_none_pc", out_pc, 32'hC);
        in_valid = 1'b0;
        tick();
        check("drain_valid", 32'(out_valid), 32'd0);
        check("drain_imm_sel", 32'(out_imm_sel), 32'd3);

        out_ready = 1'b0;
        offer(32'h00500093, 32'h0);
        tick();
        check("bp_ready_1", 32'(in_ready), 32'd1);
        offer(32'h0020A423, 32'h4);
        tick();
        check("bp_ready_full", 32'(in_ready), 32'd0);
        check("bp_head_pc", out_pc, 32'h0);
        offer(32'h00000863, 32'h8);
        tick();
        check("bp_held_ready", 32'(in_ready), 32'd0);
        check("bp_held_pc", out_pc, 32'h0);
        check("bp_held_ir", out_ir, 32'h00500093);
        out_ready = 1'b1;
        tick();
        check("bp_pop1_pc", out_pc, 32'h4);
        check("bp_pop1_ready", 32'(in_ready), 32'd1);
        tick();
        check("bp_third_pc", out_pc, 32'h8);
        check("bp_third_valid", 32'(out_valid), 32'd1);
        in_valid = 1'b0;
        tick();
        check("bp_empty", 32'(out_valid), 32'd0);

        offer(32'h00000013, 32'h100);
        tick();
        for (int i = 1; i < 10; i++) begin
            offer(32'h00000013 | 32'(i << 7), 32'h100 + 32'(4 * i));
            tick();
            check("pp_pc", out_pc, 32'h100 + 32'(4 * i));
            check("pp_ir", out_ir, 32'h00000013 | 32'(i << 7));
            check("pp_valid", 32'(out_valid), 32'd1);
            check("pp_ready", 32'(in_ready), 32'd1);
        end
        in_valid = 1'b0;
        tick();
        check("pp_empty", 32'(out_valid), 32'd0);

        out_ready = 1'b0;
        offer(32'h00500093, 32'h200);
        tick();
        offer(32'h0020A423, 32'h204);
        tick();
        check("fl_full", 32'(in_ready), 32'd0);
        flush = 1'b1;
        offer(32'h000010B7, 32'h208);
        tick();
        flush = 1'b0; in_valid = 1'b0;
        check("fl_valid", 32'(out_valid), 32'd0);
        check("fl_ready", 32'(in_ready), 32'd1);
        out_ready = 1'b1;
        tick();
        check("fl_dropped", 32'(out_valid), 32'd0);
        offer(32'h00000863, 32'h20C);
        tick();
        in_valid = 1'b0;
        check("fl_restart_pc", out_pc, 32'h20C);
        check("fl_restart_sel", 32'(out_imm_sel), 32'd2);
        out_ready = 1'b0;
        flush = 1'b1;
        offer(32'h0020A423, 32'h300);
        tick();
        flush = 1'b0; in_valid = 1'b0;
        check("fl1_push_dropped", 32'(out_valid), 32'd0);

        offer(32'h00500093, 32'h400);
        tick();
        offer(32'h0020A423, 32'h404);
        tick();
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("arst_valid", 32'(out_valid), 32'd0);
        check("arst_ready", 32'(in_ready), 32'd1);
        check("arst_pc", out_pc, 32'd0);
        #10 rst_n = 1'b1;
        tick();
        check("arst_after", 32'(out_valid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule

// File: doc/if_id_buffer.md
# if_id_buffer

- Two-entry elastic pipeline buffer between instruction fetch and the decode/immediate stage.
- Accepts fetched instruction words and PCs over a valid/ready handshake.
- Registers, per entry, the 2-bit immediate-format select that the immediate sign-extension stage consumes together with the instruction word.
- Decouples fetch stalls from decode stalls without a combinational ready path, and supports a pipeline flush.

## Interface
- PC_W, 32, width of the program-counter field carried with each instruction
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  discard all buffered entries (branch/jump redirect)
- in_valid  in  1  fetch presents an instruction
- in_ready  out  1  buffer can accept; high when fewer than 2 entries held
- in_instr  in  32  fetched instruction word
- in_pc  in  PC_W  PC of in_instr
- out_valid  out  1  head entry valid
- out_ready  in  1  decode consumes head entry
- out_ir  out  32  head instruction word (feeds immediate stage IR)
- out_pc  out  PC_W  head PC
- out_imm_sel  out  2  immediate format: 00 I, 01 S, 10 B, 11 none
- out_uses_imm  out  1  high when out_imm_sel != 11

## Operation
- Storage: 2 entries {instr, pc, imm_sel}, with a head pointer, tail pointer and count (0..2).
- Push: in_valid && in_ready && !flush. Writes the entry at the tail and decodes imm_sel from in_instr[6:0] at write time.
- Pop: out_valid && out_ready && !flush. Advances the head.
- Decode of opcode [6:0]:
  - 0010011, 0000011, 1100111 -> 00
  - 0100011 -> 01
  - 1100011 -> 10
  - all other opcodes (LUI, AUIPC, JAL, OP, SYSTEM, illegal) -> 11
- Count update:
  - push only +1
  - pop only -1
  - push and pop together: unchanged
- in_ready = (count != 2). It depends only on registered state, never on out_ready or in_valid.
- out_valid = (count != 0). out_ir, out_pc and out_imm_sel come straight from the head entry registers.
- When the head entry is invalid: out_ir = 0, out_pc = 0, out_imm_sel = 11.
- No bypass: an instruction pushed into an empty buffer appears at the output the next cycle.
- Flush has priority over push and pop. It clears count and both pointers at the next edge; a concurrent input handshake is dropped and a concurrent pop is not counted.
- Reset (asynchronous, while rst_n low): count = 0, pointers = 0, entry registers = 0, stored imm_sel = 11.
  - Outputs during reset: in_ready = 1, out_valid = 0, out_ir = 0, out_pc = 0, out_imm_sel = 11, out_uses_imm = 0.
  - Reset mid-operation discards all entries immediately, with no handshake.

## Timing
- Latency: 1 cycle from accepted input to out_valid.
- Throughput: 1 instruction/cycle sustained when out_ready stays high.
- Full (count 2): in_ready low in that same cycle. A pop in that cycle raises in_ready in the next cycle.
- Empty (count 0): out_valid low; out_ready is ignored.
- Pointers are 1 bit and wrap 1 -> 0 on increment.
- Entry data is stable while out_valid && !out_ready, as handshake rules require.
- Cycle after flush: out_valid = 0, in_ready = 1.

## Structure
- Shared package holds:
  - opcode constants OPC_OP_IMM, OPC_LOAD, OPC_JALR, OPC_STORE, OPC_BRANCH
  - IMM_SEL_I = 2'b00, IMM_SEL_S = 2'b01, IMM_SEL_B = 2'b10, IMM_SEL_NONE = 2'b11
  - the entry struct {instr, pc, imm_sel}
  
  The immediate stage uses the same encodings.
- Sub-module imm_sel_decode: combinational, opcode[6:0] -> imm_sel[1:0]. It is instantiated once, on the write path.

## Test plan
- Reset: hold rst_n low with in_valid = 1 -> in_ready = 1, out_valid = 0, out_imm_sel = 11. Release reset -> first push appears after 1 cycle.
- Formats: push 0x00500093 (addi), 0x0020A423 (sw), 0x00000863 (beq), 0x000010B7 (lui), PCs 0x0, 0x4, 0x8, 0xC, with out_ready = 1:
  - out_imm_sel 00, 01, 10, 11 on consecutive cycles
  - out_uses_imm 1, 1, 1, 0
- Backpressure: out_ready = 0 while pushing 3 instructions:
  - in_ready drops after 2 accepts; the third is held at the input
  - raising out_ready pops in order, PCs 0x0 then 0x4, and the third is accepted in the cycle after the first pop
- Simultaneous push and pop at count 1: count stays 1, order is preserved, no bubble over 10 back-to-back instructions.
- Flush while full with in_valid = 1:
  - next cycle out_valid = 0, in_ready = 1
  - the instruction offered in the flush cycle never appears
- Async reset asserted mid-stream between clock edges -> out_valid falls immediately; buffer is empty after release.
